// File: rtl/io_port_if.sv
// io_port device-side channels: a valid/ready producer channel into the
// input FIFO and a 4-phase valid/ack consumer channel out of the output register.
// master = external device side, slave = io_port side.
interface io_port_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dev_in_data;
    logic             dev_in_valid;
    logic             dev_in_ready;
    logic [WIDTH-1:0] dev_out_data;
    logic             dev_out_valid;
    logic             dev_out_ack;

    modport master (
        output dev_in_data,
        output dev_in_valid,
        input  dev_in_ready,
        input  dev_out_data,
        input  dev_out_valid,
        output dev_out_ack
    );

    modport slave (
        input  dev_in_data,
        input  dev_in_valid,
        output dev_in_ready,
        output dev_out_data,
        output dev_out_valid,
        input  dev_out_ack
    );
endinterface

// File: rtl/io_port.sv
// io_port: input FIFO feeding an input register toward the bus mux, plus an
// output register with a 4-phase handshake toward an external consumer.
// Optional feature macro: IO_LOOPBACK_EN adds lb_mode, which routes
// OutPortIn writes back into the input FIFO instead of the consumer.
//
// Output FSM
//   state   | meaning
//   IDLE    | nothing pending for the consumer
//   PRESENT | output register valid, waiting for dev_out_ack=1
//   ACKED   | consumer acked, waiting for dev_out_ack=0
module io_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                          Clock,
    input  logic                          Reset,
`ifdef IO_LOOPBACK_EN
    input  logic                          lb_mode,
`endif
    input  logic                          clear,
    input  logic                          strobe,
    input  logic                          InPortout,
    input  logic                          OutPortIn,
    input  logic [WIDTH-1:0]              BusMuxOut,
    output logic [WIDTH-1:0]              InPort_data_out,
    io_port_if.slave                      dev,
    output logic [$clog2(FIFO_DEPTH):0]   in_count,
    output logic                          in_underflow,
    output logic                          out_overwrite
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, PRESENT, ACKED} out_state_t;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [WIDTH-1:0] in_reg, out_reg, push_data;
    logic             strobe_q;
    logic             lb_active, full, empty, push, pop, pop_req, ow_set;
    out_state_t       state, state_nxt;

`ifdef IO_LOOPBACK_EN
    assign lb_active = lb_mode;
`else
    assign lb_active = 1'b0;
`endif

    assign full      = (in_count == CW'(FIFO_DEPTH));
    assign empty     = (in_count == '0);
    assign dev.dev_in_ready = !full && !lb_active;
    // in loopback the bus write lands in the FIFO; a full FIFO silently drops it
    assign push      = lb_active ? (OutPortIn && !full) : (dev.dev_in_valid && dev.dev_in_ready);
    assign push_data = lb_active ? BusMuxOut : dev.dev_in_data;
    assign pop_req   = strobe && !strobe_q;
    assign pop       = pop_req && !empty;

    assign InPort_data_out   = InPortout ? in_reg : '0;
    assign dev.dev_out_data  = out_reg;
    assign dev.dev_out_valid = (state == PRESENT);

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge Clock) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy, input register, strobe history, sticky flags
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            in_count      <= '0;
            in_reg        <= '0;
            strobe_q      <= 1'b0;
            in_underflow  <= 1'b0;
            out_overwrite <= 1'b0;
            out_reg       <= '0;
            state         <= IDLE;
        end else if (clear) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            in_count      <= '0;
            in_reg        <= '0;
            strobe_q      <= 1'b0;
            in_underflow  <= 1'b0;
            out_overwrite <= 1'b0;
            out_reg       <= '0;
            state         <= IDLE;
        end else begin
            strobe_q <= strobe;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                in_reg <= mem[rd_ptr];
            end
            if (pop_req && empty) in_underflow <= 1'b1;
            in_count <= in_count + CW'(push) - CW'(pop);
            if (OutPortIn) out_reg <= BusMuxOut;
            if (ow_set) out_overwrite <= 1'b1;
            state <= state_nxt;
        end
    end

    // output handshake next-state; a bus write restarts presentation from any state
    always_comb begin
        state_nxt = state;
        ow_set    = 1'b0;
        if (OutPortIn && !lb_active) begin
            state_nxt = PRESENT;
            ow_set    = (state == PRESENT);
        end else begin
            case (state)
                PRESENT: if (dev.dev_out_ack)  state_nxt = ACKED;
                ACKED:   if (!dev.dev_out_ack) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end
endmodule

// File: tb/tb_io_port.sv
module tb_io_port;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        clear = 1'b0;
    logic        strobe = 1'b0;
    logic        InPortout = 1'b0;
    logic        OutPortIn = 1'b0;
    logic [31:0] BusMuxOut = '0;
    logic [31:0] InPort_data_out;
    logic [2:0]  in_count;
    logic        in_underflow, out_overwrite;
`ifdef IO_LOOPBACK_EN
    logic        lb_mode = 1'b0;
`endif

    io_port_if #(.WIDTH(32)) bus_if ();

    io_port #(.FIFO_DEPTH(4), .WIDTH(32)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
`ifdef IO_LOOPBACK_EN
        .lb_mode         (lb_mode),
`endif
        .clear           (clear),
        .strobe          (strobe),
        .InPortout       (InPortout),
        .OutPortIn       (OutPortIn),
        .BusMuxOut       (BusMuxOut),
        .InPort_data_out (InPort_data_out),
        .dev             (bus_if),
        .in_count        (in_count),
        .in_underflow    (in_underflow),
        .out_overwrite   (out_overwrite)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        s, ipo, opi, dv, ack, clr;
        logic [31:0] bus, din;
        logic [31:0] e_cnt;
        logic        e_rdy;
        logic [31:0] e_inp;
        logic        e_oval;
        logic [31:0] e_od;
        logic        e_uf, e_ow;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic v(input logic s, ipo, opi, input logic [31:0] bus, input logic dv,
                     input logic [31:0] din, input logic ack, clr, input logic [31:0] cnt,
                     input logic rdy, input logic [31:0] inp, input logic oval,
                     input logic [31:0] od, input logic uf, ow);
        vec_t r;
        r.s = s; r.ipo = ipo; r.opi = opi; r.bus = bus; r.dv = dv; r.din = din;
        r.ack = ack; r.clr = clr; r.e_cnt = cnt; r.e_rdy = rdy; r.e_inp = inp;
        r.e_oval = oval; r.e_od = od; r.e_uf = uf; r.e_ow = ow;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] cnt, input logic rdy,
                           input logic [31:0] inp, input logic oval, input logic [31:0] od,
                           input logic uf, input logic ow);
        chk({tag, " in_count"}, {29'b0, in_count}, cnt);
        chk({tag, " dev_in_ready"}, {31'b0, bus_if.dev_in_ready}, {31'b0, rdy});
        chk({tag, " InPort_data_out"}, InPort_data_out, inp);
        chk({tag, " dev_out_valid"}, {31'b0, bus_if.dev_out_valid}, {31'b0, oval});
        chk({tag, " dev_out_data"}, bus_if.dev_out_data, od);
        chk({tag, " in_underflow"}, {31'b0, in_underflow}, {31'b0, uf});
        chk({tag, " out_overwrite"}, {31'b0, out_overwrite}, {31'b0, ow});
    endtask

    task automatic drive(input logic s, ipo, opi, input logic [31:0] bus, input logic dv,
                         input logic [31:0] din, input logic ack, clr);
        strobe = s; InPortout = ipo; OutPortIn = opi; BusMuxOut = bus;
        bus_if.dev_in_valid = dv; bus_if.dev_in_data = din;
        bus_if.dev_out_ack = ack; clear = clr;
    endtask

    initial begin
        bus_if.dev_in_valid = 1'b0;
        bus_if.dev_in_data  = '0;
        bus_if.dev_out_ack  = 1'b0;

        //  s ipo opi bus           dv din    ack clr | cnt rdy inport        oval odata        uf ow
        v(0, 0, 0, 32'h0,        1, 32'h11, 0, 0,   1, 1, 32'h0,        0, 32'h0,        0, 0);
        v(0, 0, 0, 32'h0,        1, 32'h22, 0, 0,   2, 1, 32'h0,        0, 32'h0,        0, 0);
        v(0, 0, 0, 32'h0,        1, 32'h33, 0, 0,   3, 1, 32'h0,        0, 32'h0,        0, 0);
        v(0, 0, 0, 32'h0,        1, 32'h44, 0, 0,   4, 0, 32'h0,        0, 32'h0,        0, 0);
        v(0, 0, 0, 32'h0,        1, 32'h55, 0, 0,   4, 0, 32'h0,        0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   3, 1, 32'h11,       0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   3, 1, 32'h11,       0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   3, 1, 32'h11,       0, 32'h0,        0, 0);
        v(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,   3, 1, 32'h11,       0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   2, 1, 32'h22,       0, 32'h0,        0, 0);
        v(0, 0, 0, 32'h0,        1, 32'h66, 0, 0,   3, 1, 32'h0,        0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        1, 32'h77, 0, 0,   3, 1, 32'h33,       0, 32'h0,        0, 0);
        v(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,   3, 1, 32'h33,       0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   2, 1, 32'h44,       0, 32'h0,        0, 0);
        v(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,   2, 1, 32'h44,       0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   1, 1, 32'h66,       0, 32'h0,        0, 0);
        v(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,   1, 1, 32'h66,       0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   0, 1, 32'h77,       0, 32'h0,        0, 0);
        v(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,   0, 1, 32'h77,       0, 32'h0,        0, 0);
        v(1, 1, 0, 32'h0,        1, 32'hAB, 0, 0,   1, 1, 32'h77,       0, 32'h0,        1, 0);
        v(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,   1, 1, 32'h77,       0, 32'h0,        1, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,   0, 1, 32'hAB,       0, 32'h0,        1, 0);
        v(0, 1, 0, 32'h0,        0, 32'h0,  0, 1,   0, 1, 32'h0,        0, 32'h0,        0, 0);
        v(0, 0, 1, 32'hDEADBEEF, 0, 32'h0,  0, 0,   0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,  1, 0,   0, 1, 32'h0,        0, 32'hDEADBEEF, 0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,  0, 0,   0, 1, 32'h0,        0, 32'hDEADBEEF, 0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,  1, 0,   0, 1, 32'h0,        0, 32'hDEADBEEF, 0, 0);
        v(0, 0, 1, 32'h1,        0, 32'h0,  0, 0,   0, 1, 32'h0,        1, 32'h1,        0, 0);
        v(0, 0, 1, 32'h2,        0, 32'h0,  0, 0,   0, 1, 32'h0,        1, 32'h2,        0, 1);
        v(0, 0, 0, 32'h0,        0, 32'h0,  1, 0,   0, 1, 32'h0,        0, 32'h2,        0, 1);
        v(0, 0, 1, 32'h3,        0, 32'h0,  1, 0,   0, 1, 32'h0,        1, 32'h3,        0, 1);
        v(0, 0, 0, 32'h0,        0, 32'h0,  0, 1,   0, 1, 32'h0,        0, 32'h0,        0, 0);
        v(0, 0, 1, 32'h1,        0, 32'h0,  0, 0,   0, 1, 32'h0,        1, 32'h1,        0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,  1, 0,   0, 1, 32'h0,        0, 32'h1,        0, 0);
        v(0, 0, 1, 32'h9,        0, 32'h0,  1, 0,   0, 1, 32'h0,        1, 32'h9,        0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,  1, 0,   0, 1, 32'h0,        0, 32'h9,        0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,  1, 0,   0, 1, 32'h0,        0, 32'h9,        0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,  0, 0,   0, 1, 32'h0,        0, 32'h9,        0, 0);

        // reset state, sampled while Reset is still asserted
        InPortout = 1'b1;
        #12;
        chk_all("reset", 0, 1, 32'h0, 0, 32'h0, 0, 0);
        Reset = 1'b0;
        InPortout = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s, vecs[i].ipo, vecs[i].opi, vecs[i].bus, vecs[i].dv,
                  vecs[i].din, vecs[i].ack, vecs[i].clr);
            @(posedge Clock);
            #1;
            chk_all($sformatf("row%0d", i), vecs[i].e_cnt, vecs[i].e_rdy, vecs[i].e_inp,
                    vecs[i].e_oval, vecs[i].e_od, vecs[i].e_uf, vecs[i].e_ow);
        end

        // strobe held through clear: history is zeroed, so the next edge pops (empty -> underflow)
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        @(posedge Clock); #1;
        chk("clr_strobe uf_after_clear", {31'b0, in_underflow}, 32'h0);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        @(posedge Clock); #1;
        chk("clr_strobe uf_next", {31'b0, in_underflow}, 32'h1);

        // async reset in the middle of a presentation with overwrite pending
        drive(0, 0, 1, 32'h1, 0, 32'h0, 0, 0);
        @(posedge Clock); #1;
        drive(0, 0, 1, 32'h2, 0, 32'h0, 0, 0);
        @(posedge Clock); #1;
        chk("pre_reset valid", {31'b0, bus_if.dev_out_valid}, 32'h1);
        chk("pre_reset ow", {31'b0, out_overwrite}, 32'h1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        #2 Reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 1, 32'h0, 0, 32'h0, 0, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("post_reset valid", {31'b0, bus_if.dev_out_valid}, 32'h0);

`ifdef IO_LOOPBACK_EN
        lb_mode = 1'b1;
        drive(0, 0, 1, 32'h5A, 1, 32'h99, 0, 0);
        @(posedge Clock); #1;
        chk_all("lb_write", 1, 0, 32'h0, 0, 32'h5A, 0, 0);
        drive(1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        @(posedge Clock); #1;
        chk_all("lb_pop", 0, 0, 32'h5A, 0, 32'h5A, 0, 0);
        lb_mode = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        @(posedge Clock); #1;
        chk("lb_off ready", {31'b0, bus_if.dev_in_ready}, 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_port.md
IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input FIFO entry count; power of two, 2..16.
REQ-002 Parameter WIDTH, default 32, data width of bus, FIFO and port registers.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous clear from control unit; same effect as Reset, applied at the clock edge.
REQ-006 strobe  input  1  control-unit request to pop the input FIFO head into the input register.
REQ-007 InPortout  input  1  control-unit enable for driving the input register toward the bus mux.
REQ-008 OutPortIn  input  1  control-unit enable for capturing BusMuxOut into the output register.
REQ-009 BusMuxOut  input  WIDTH  datapath bus value.
REQ-010 InPort_data_out  output  WIDTH  input register when InPortout=1, else 0.
REQ-011 dev_in_data / dev_in_valid / dev_in_ready  input WIDTH / input 1 / output 1  external producer valid-ready channel.
REQ-012 dev_out_data / dev_out_valid / dev_out_ack  output WIDTH / output 1 / input 1  external consumer, 4-phase handshake.
REQ-013 in_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 in_underflow, out_overwrite  output  1 each  sticky error flags.

Function
REQ-015 Push: entry accepted on an edge with dev_in_valid=1 and dev_in_ready=1; dev_in_ready = (in_count != FIFO_DEPTH), combinational, independent of same-cycle pop.
REQ-016 strobe is edge-detected: a pop occurs only on the first clock where strobe=1 after a sample of 0; a strobe held for N cycles pops exactly once.
REQ-017 Pop with FIFO non-empty: head loads the input register at that edge, occupancy decrements; visible on InPort_data_out the next cycle.
REQ-018 Pop with FIFO empty (including simultaneous push into an empty FIFO): input register holds, in_underflow set; the push still lands and in_count becomes 1.
REQ-019 Simultaneous push and pop on non-empty, non-full FIFO: in_count unchanged, ordering preserved; pointers wrap modulo FIFO_DEPTH.
REQ-020 Output FSM states: IDLE, PRESENT, ACKED; dev_out_valid=1 only in PRESENT.
REQ-021 OutPortIn=1 at an edge: output register <= BusMuxOut and state -> PRESENT, from any state.
REQ-022 OutPortIn while state is PRESENT: data overwritten (latest wins), out_overwrite set.
REQ-023 PRESENT with dev_out_ack=1 -> ACKED; ACKED with dev_out_ack=0 -> IDLE; ACKED with OutPortIn -> PRESENT (not an overwrite).
REQ-024 dev_out_data always shows the output register; it changes only on OutPortIn.
REQ-025 No combinational path from dev_out_ack or dev_in_valid to any output except through registered state.

Reset
REQ-026 Reset or clear: FIFO emptied (in_count=0), input and output registers 0, FSM IDLE, dev_out_valid=0, both sticky flags 0, strobe edge-detector history 0.
REQ-027 dev_in_ready is 1 immediately after reset/clear.
REQ-028 Reset asserted mid-handshake drops dev_out_valid asynchronously; no pending output is retained.

Configuration
REQ-029 Macro IO_LOOPBACK_EN: when defined, adds input port lb_mode (1 bit); with lb_mode=1, OutPortIn also pushes BusMuxOut into the input FIFO (dropped if full), external pushes are blocked (dev_in_ready=0), and the output FSM stays IDLE.
REQ-030 Without IO_LOOPBACK_EN: no lb_mode port; behaviour exactly as REQ-015..REQ-025.

Verification
REQ-031 Push 0x11,0x22,0x33,0x44 with FIFO_DEPTH=4 -> in_count=4, dev_in_ready=0; fifth valid not accepted.
REQ-032 Strobe held 3 cycles after the fill above -> one pop, InPort_data_out=0x11 with InPortout=1, in_count=3.
REQ-033 Strobe on empty FIFO with a same-cycle push of 0xAB -> in_underflow=1, register unchanged, in_count=1; next strobe yields 0xAB.
REQ-034 OutPortIn with BusMuxOut=0xDEADBEEF -> dev_out_valid=1 next cycle; ack=1 -> valid=0; ack=0 -> IDLE.
REQ-035 Two OutPortIn (0x1, 0x2) before any ack -> dev_out_data=0x2, out_overwrite=1; Reset mid-PRESENT -> valid=0, flags cleared.
REQ-036 With IO_LOOPBACK_EN, lb_mode=1, OutPortIn with 0x5A -> in_count=1, dev_out_valid stays 0; strobe -> InPort_data_out=0x5A.
